// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU operation sequencer.
// Optional build macro used by the top: ALU_SEQ_DIVZERO_EN.
package alu_seq_pkg;

  localparam int BITS_DEF      = 32;
  localparam int SIG_COUNT_DEF = 12;
  localparam int NUM_OPS       = 12;

  // Opcode value doubles as the index of its bit in the one-hot control word.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_SHR = 4'd4,
    OP_SHL = 4'd5,
    OP_ROR = 4'd6,
    OP_ROL = 4'd7,
    OP_AND = 4'd8,
    OP_OR  = 4'd9,
    OP_NEG = 4'd10,
    OP_NOT = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU control word plus illegal-opcode flag.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int SIG_COUNT = SIG_COUNT_DEF
) (
  input  logic [3:0]           op,
  output logic [SIG_COUNT-1:0] ctrl,
  output logic                 illegal
);

  assign illegal = (op >= 4'(NUM_OPS));

  generate
    for (genvar gi = 0; gi < SIG_COUNT; gi++) begin : g_bit
      if (gi < NUM_OPS) begin : g_op
        assign ctrl[gi] = (op == 4'(gi));
      end else begin : g_pad
        assign ctrl[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time, waits its settle time, returns the result.
// Build macro ALU_SEQ_DIVZERO_EN: reject divide-by-zero like an illegal opcode.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BITS        = BITS_DEF,
  parameter int SIG_COUNT   = SIG_COUNT_DEF,
  parameter int ALU_WAIT    = 1,
  parameter int MULDIV_WAIT = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           op,
  input  logic [BITS-1:0]      x,
  input  logic [BITS-1:0]      y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [2*BITS-1:0]    alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      hi,
  output logic [BITS-1:0]      lo,
  output logic                 rsp_err
);

  localparam int MAX_WAIT = (ALU_WAIT > MULDIV_WAIT) ? ALU_WAIT : MULDIV_WAIT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;
  // Counter holds remaining cycles minus one, so it hits zero on the capture edge.
  localparam logic [CW-1:0] ALU_LOAD    = CW'(ALU_WAIT - 1);
  localparam logic [CW-1:0] MULDIV_LOAD = CW'(MULDIV_WAIT - 1);

  seq_state_e           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [SIG_COUNT-1:0] ctrl_reg, ctrl_next;
  logic                 illegal_reg, illegal_next;
  logic [BITS-1:0]      x_reg, x_next;
  logic [BITS-1:0]      y_reg, y_next;
  logic [BITS-1:0]      hi_reg, hi_next;
  logic [BITS-1:0]      lo_reg, lo_next;
  logic                 err_reg, err_next;

  logic [SIG_COUNT-1:0] dec_ctrl;
  logic                 dec_illegal;
  logic                 reject;

  alu_op_decode #(
    .SIG_COUNT(SIG_COUNT)
  ) u_decode (
    .op     (op),
    .ctrl   (dec_ctrl),
    .illegal(dec_illegal)
  );

`ifdef ALU_SEQ_DIVZERO_EN
  assign reject = dec_illegal || ((op == OP_DIV) && (y == '0));
`else
  assign reject = dec_illegal;
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ctrl_next    = ctrl_reg;
    illegal_next = illegal_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    err_next     = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          x_next       = x;
          y_next       = y;
          ctrl_next    = reject ? '0 : dec_ctrl;
          illegal_next = reject;
          cnt_next     = is_muldiv(op) ? MULDIV_LOAD : ALU_LOAD;
          state_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Rejected requests pass through EXEC for one cycle with the ALU idle.
        if (illegal_reg) begin
          hi_next    = '0;
          lo_next    = '0;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end else if (cnt_reg == '0) begin
          hi_next    = alu_result[2*BITS-1:BITS];
          lo_next    = alu_result[BITS-1:0];
          err_next   = 1'b0;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      ctrl_reg    <= '0;
      illegal_reg <= 1'b0;
      x_reg       <= '0;
      y_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ctrl_reg    <= ctrl_next;
      illegal_reg <= illegal_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      err_reg     <= err_next;
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign alu_ctrl  = (state_reg == ST_EXEC) ? ctrl_reg : '0;
  assign alu_x     = x_reg;
  assign alu_y     = y_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer with a reference ALU model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_x, alu_y;
  logic [63:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] hi, lo;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .alu_ctrl  (alu_ctrl),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .hi        (hi),
    .lo        (lo),
    .rsp_err   (rsp_err)
  );

  // Reference ALU; an undriven control word yields a marker value.
  logic signed [63:0] sx, sy, q, r;
  logic [63:0]        dbl_r, dbl_l;
  always_comb begin
    sx         = {{32{alu_x[31]}}, alu_x};
    sy         = {{32{alu_y[31]}}, alu_y};
    q          = '0;
    r          = '0;
    dbl_r      = {alu_x, alu_x} >> alu_y[4:0];
    dbl_l      = {alu_x, alu_x} << alu_y[4:0];
    alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    case (alu_ctrl)
      12'h001: alu_result = sx + sy;
      12'h002: alu_result = sx - sy;
      12'h004: alu_result = sx * sy;
      12'h008: begin
        if (alu_y == '0) begin
          alu_result = {alu_x, 32'hFFFF_FFFF};
        end else begin
          q          = sx / sy;
          r          = sx % sy;
          alu_result = {r[31:0], q[31:0]};
        end
      end
      12'h010: alu_result = {32'h0, alu_x >> alu_y[4:0]};
      12'h020: alu_result = {32'h0, alu_x << alu_y[4:0]};
      12'h040: alu_result = {32'h0, dbl_r[31:0]};
      12'h080: alu_result = {32'h0, dbl_l[63:32]};
      12'h100: alu_result = {32'h0, alu_x & alu_y};
      12'h200: alu_result = {32'h0, alu_x | alu_y};
      12'h400: alu_result = -sx;
      12'h800: alu_result = {32'h0, ~alu_x};
      default: alu_result = 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          cycles;
    logic [11:0] ctrl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int hold);
    check("req_ready_before", req_ready, 1);
    req_valid = 1'b1;
    op = v.op;
    x  = v.x;
    y  = v.y;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op = ~v.op;
    x  = ~v.x;
    y  = $urandom;
    for (int i = 0; i < v.cycles; i++) begin
      check("exec_alu_ctrl", alu_ctrl, v.ctrl);
      check("exec_rsp_valid", rsp_valid, 0);
      check("exec_req_ready", req_ready, 0);
      check("exec_alu_x", alu_x, v.x);
      check("exec_alu_y", alu_y, v.y);
      @(posedge clk); #1;
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_alu_ctrl", alu_ctrl, 0);
    check("rsp_hi", hi, v.hi);
    check("rsp_lo", lo, v.lo);
    check("rsp_err", rsp_err, v.err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_hi", hi, v.hi);
      check("hold_lo", lo, v.lo);
      check("hold_err", rsp_err, v.err);
      check("hold_alu_ctrl", alu_ctrl, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_hi", hi, v.hi);
    check("post_lo", lo, v.lo);
    $display("txn op=%0d x=%h y=%h hold=%0d -> hi=%h lo=%h err=%0d", v.op, v.x, v.y, hold, hi, lo, rsp_err);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'd3,          32'd5,          1, 12'h001, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[1]  = '{4'd1,  32'd3,          32'd5,          1, 12'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{4'd2,  32'hFFFF_FFF1,  32'd5,          3, 12'h004, 32'hFFFF_FFFF, 32'hFFFF_FFB5, 1'b0};
    vecs[3]  = '{4'd3,  32'd100,        32'd7,          3, 12'h008, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[4]  = '{4'd4,  32'h8000_0000,  32'd4,          1, 12'h010, 32'h0000_0000, 32'h0800_0000, 1'b0};
    vecs[5]  = '{4'd5,  32'd1,          32'd31,         1, 12'h020, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{4'd6,  32'h0000_000F,  32'd4,          1, 12'h040, 32'h0000_0000, 32'hF000_0000, 1'b0};
    vecs[7]  = '{4'd7,  32'hF000_0001,  32'd4,          1, 12'h080, 32'h0000_0000, 32'h0000_001F, 1'b0};
    vecs[8]  = '{4'd8,  32'h0000_F0F0,  32'h0000_FF00,  1, 12'h100, 32'h0000_0000, 32'h0000_F000, 1'b0};
    vecs[9]  = '{4'd9,  32'h0000_F0F0,  32'h0000_0F0F,  1, 12'h200, 32'h0000_0000, 32'h0000_FFFF, 1'b0};
    vecs[10] = '{4'd10, 32'd5,          32'd0,          1, 12'h400, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0};
    vecs[11] = '{4'd11, 32'd0,          32'd0,          1, 12'h800, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{4'd13, 32'd7,          32'd9,          1, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{4'd15, 32'd7,          32'd9,          1, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b1};
`ifdef ALU_SEQ_DIVZERO_EN
    vecs[14] = '{4'd3,  32'd9,          32'd0,          1, 12'h000, 32'h0000_0000, 32'h0000_0000, 1'b1};
`else
    vecs[14] = '{4'd3,  32'd9,          32'd0,          3, 12'h008, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_ctrl", alu_ctrl, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_err", rsp_err, 0);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i], 0);
    end

    // Response back-pressure on a mul
    run_op(vecs[2], 5);

    // Reset during the second EXEC cycle of a mul
    req_valid = 1'b1;
    op = vecs[2].op;
    x  = vecs[2].x;
    y  = vecs[2].y;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_exec1_ctrl", alu_ctrl, 12'h004);
    @(posedge clk); #1;
    check("rst_exec2_ctrl", alu_ctrl, 12'h004);
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_alu_x", alu_x, 0);
    check("rst_alu_y", alu_y, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_no_response", rsp_valid, 0);
    end
    $display("txn reset mid-mul: no response, req_ready=%0d", req_ready);

    run_op(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
